// File: rtl/edge_frame_pkg.sv
// edge_frame_pkg
// Shared definitions for the edge frame writer:
//   - state_t      : frame tracking FSM encoding (WAIT / ACTIVE / DONE)
//   - DEF_WIDTH/DEF_HEIGHT : default frame geometry (640x480)
//   - PIX_W, WORD_W, COL_W, GHI_W, GLO_W : pixel and packed-word field widths
//   - pack_wr1/pack_wr2 : pack a grey pixel (R = G = B) into the two
//     16-bit SDRAM write-port words of the display path.
package edge_frame_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  localparam int PIX_W  = 12;  // edge magnitude width
  localparam int WORD_W = 16;  // SDRAM write-port word width
  localparam int COL_W  = 10;  // colour field width (top bits of the pixel)
  localparam int GHI_W  = 5;   // green upper half, lives in word 1
  localparam int GLO_W  = 5;   // green lower half, lives in word 2

  // Word 1: {1'b0, G[11:7], B[11:2]}
  function automatic logic [WORD_W-1:0] pack_wr1(input logic [PIX_W-1:0] p);
    return {1'b0, p[PIX_W-1 -: GHI_W], p[PIX_W-1 -: COL_W]};
  endfunction

  // Word 2: {1'b0, G[6:2], R[11:2]}
  function automatic logic [WORD_W-1:0] pack_wr2(input logic [PIX_W-1:0] p);
    return {1'b0, p[PIX_W-1-GHI_W -: GLO_W], p[PIX_W-1 -: COL_W]};
  endfunction

endpackage

// File: rtl/edge_frame_position.sv
// edge_frame_position
// Pixel / line position counters for one frame.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : restart the frame; position becomes (0,0) this cycle
//   i_advance    : a pixel is consumed at the current (post-clear) position
//   o_px, o_ln   : registered pixel and line counters
//   o_last       : the current (post-clear) position is the last pixel
// WIDTH and HEIGHT must both be at least 2.
module edge_frame_position #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic                      i_advance,
  output logic [$clog2(WIDTH)-1:0]  o_px,
  output logic [$clog2(HEIGHT)-1:0] o_ln,
  output logic                      o_last
);

  localparam int PW = $clog2(WIDTH);
  localparam int LW = $clog2(HEIGHT);

  logic [PW-1:0] r_px;
  logic [LW-1:0] r_ln;
  logic [PW-1:0] w_px_base;
  logic [LW-1:0] w_ln_base;
  logic          w_px_end;
  logic          w_ln_end;

  // A clear coinciding with an advance makes the advancing beat pixel (0,0).
  assign w_px_base = i_clear ? '0 : r_px;
  assign w_ln_base = i_clear ? '0 : r_ln;
  assign w_px_end  = (w_px_base == PW'(WIDTH - 1));
  assign w_ln_end  = (w_ln_base == LW'(HEIGHT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_px <= '0;
      r_ln <= '0;
    end else if (i_advance) begin
      if (w_px_end) begin
        r_px <= '0;
        r_ln <= w_ln_end ? '0 : w_ln_base + 1'b1;
      end else begin
        r_px <= w_px_base + 1'b1;
        r_ln <= w_ln_base;
      end
    end else if (i_clear) begin
      r_px <= '0;
      r_ln <= '0;
    end
  end

  assign o_px   = r_px;
  assign o_ln   = r_ln;
  assign o_last = w_px_end & w_ln_end;

endmodule

// File: rtl/edge_frame_writer.sv
// edge_frame_writer
// Turns the Sobel edge magnitude stream into SDRAM write-port words and
// tracks frame position, completion, truncation and dropped pixels.
//   iCLK, iRST   : pixel clock, asynchronous active-high reset
//   iDATA/iDVAL  : edge magnitude and its valid (no upstream stall exists)
//   iFVAL        : frame valid; rising edge starts a frame
//   iFULL        : SDRAM write FIFO full; beats seen while full are dropped
//   oWR1_DATA/oWR2_DATA/oWR_EN : packed words and their write strobe
//   oFRAME_DONE/oFRAME_ERR     : one-cycle completion / truncation pulses
//   oFRAME_CNT/oDROP_CNT       : completed frames (wraps), drops (saturates)
//   oSTATE, oPX, oLN           : debug view of FSM state and position
// Build option: EDGE_THRESHOLD_EN binarises the pixel against THRESHOLD.
//
// Handshake: iDVAL is a strict valid with no ready; every iDVAL beat inside
// a frame is consumed in the cycle it is presented. oWR_EN is a valid toward
// the FIFO whose only back-pressure is iFULL, sampled with the same beat.
module edge_frame_writer
  import edge_frame_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
`ifdef EDGE_THRESHOLD_EN
  ,
  parameter logic [PIX_W-1:0] THRESHOLD = 12'd256
`endif
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [PIX_W-1:0]          iDATA,
  input  logic                      iDVAL,
  input  logic                      iFVAL,
  input  logic                      iFULL,
  output logic [WORD_W-1:0]         oWR1_DATA,
  output logic [WORD_W-1:0]         oWR2_DATA,
  output logic                      oWR_EN,
  output logic                      oFRAME_DONE,
  output logic                      oFRAME_ERR,
  output logic [15:0]               oFRAME_CNT,
  output logic [15:0]               oDROP_CNT,
  output logic [1:0]                oSTATE,
  output logic [$clog2(WIDTH)-1:0]  oPX,
  output logic [$clog2(HEIGHT)-1:0] oLN
);

  state_t            r_state;
  logic              r_fval_d;
  logic              r_seen_low;
  logic              r_wr_en;
  logic              r_done;
  logic              r_err;
  logic [WORD_W-1:0] r_wr1;
  logic [WORD_W-1:0] r_wr2;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_drop_cnt;

  logic              w_rise;
  logic              w_fall;
  logic              w_active;
  logic              w_in_frame;
  logic              w_beat;
  logic              w_last;
  logic [PIX_W-1:0]  w_pix;

  // A frame already in progress when reset releases has no visible rising
  // edge; r_seen_low keeps it from being mistaken for a fresh start.
  assign w_rise     = iFVAL & ~r_fval_d & r_seen_low;
  assign w_fall     = ~iFVAL & r_fval_d;
  assign w_active   = (r_state == ST_ACTIVE);
  // A rising edge in any state starts (or restarts) the frame, and the
  // coincident beat is pixel (0,0). A falling edge wins over a beat.
  assign w_in_frame = w_rise | (w_active & ~w_fall);
  assign w_beat     = w_in_frame & iDVAL;

`ifdef EDGE_THRESHOLD_EN
  assign w_pix = (iDATA >= THRESHOLD) ? 12'hFFF : 12'h000;
`else
  assign w_pix = iDATA;
`endif

  edge_frame_position #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_pos (
    .i_clk    (iCLK),
    .i_rst    (iRST),
    .i_clear  (w_rise),
    .i_advance(w_beat),
    .o_px     (oPX),
    .o_ln     (oLN),
    .o_last   (w_last)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= ST_WAIT;
      r_fval_d    <= 1'b0;
      r_seen_low  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wr1       <= '0;
      r_wr2       <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_fval_d <= iFVAL;
      if (!iFVAL) r_seen_low <= 1'b1;

      r_wr_en <= w_beat & ~iFULL;
      r_done  <= w_beat & w_last;
      r_err   <= w_active & (w_rise | w_fall);

      if (w_beat && !iFULL) begin
        r_wr1 <= pack_wr1(w_pix);
        r_wr2 <= pack_wr2(w_pix);
      end
      // Geometry still advances on a dropped beat; only the count records it.
      if (w_beat && iFULL && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_beat && w_last)
        r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_beat && w_last)
        r_state <= ST_DONE;
      else if (w_rise)
        r_state <= ST_ACTIVE;
      else begin
        case (r_state)
          ST_ACTIVE: if (w_fall) r_state <= ST_WAIT;
          ST_DONE:   if (!iFVAL) r_state <= ST_WAIT;
          default:   r_state <= r_state;
        endcase
      end
    end
  end

  assign oWR1_DATA   = r_wr1;
  assign oWR2_DATA   = r_wr2;
  assign oWR_EN      = r_wr_en;
  assign oFRAME_DONE = r_done;
  assign oFRAME_ERR  = r_err;
  assign oFRAME_CNT  = r_frame_cnt;
  assign oDROP_CNT   = r_drop_cnt;
  assign oSTATE      = r_state;

endmodule
